// File: rtl/flex_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flex_fifo_ctrl
// Purpose  : Single-clock pointer/flag controller for the flex FIFO storage
//            array (async-read, sync-write, DATA_WIDTH x 2**ADDR_WIDTH).
//            Generates the array write enable and write/read addresses and
//            presents first-word-fall-through semantics: the word at raddr_o
//            is valid in any cycle where empty_o is low. Buffers shifted
//            TDI/TDO bytes between the TAP side and the bus side.
//
// Parameters:
//   ADDR_WIDTH    : array address width, depth = 2**ADDR_WIDTH
//   AFULL_THRESH  : almost_full_o asserts when count_o >= AFULL_THRESH
//   AEMPTY_THRESH : almost_empty_o asserts when count_o <= AEMPTY_THRESH
//
// Ports:
//   clk            in   single clock (array wclk is tied to this clock)
//   rst            in   synchronous reset, active-high
//   wr_req_i       in   push request (data goes to the array directly)
//   rd_req_i       in   pop request, consumes the word at raddr_o
//   clear_i        in   synchronous flush of both pointers
//   wclk_en_o      out  array write enable (combinational)
//   waddr_o        out  array write address
//   raddr_o        out  array read address
//   full_o         out  no free entries
//   empty_o        out  no valid entries
//   almost_full_o  out  count_o >= AFULL_THRESH
//   almost_empty_o out  count_o <= AEMPTY_THRESH
//   count_o        out  number of valid entries, 0..2**ADDR_WIDTH
//   overflow_o     out  sticky: push attempted while full   (optional)
//   underflow_o    out  sticky: pop attempted while empty   (optional)
//
// Optional feature macro: FLEX_FIFO_CTRL_ERR_FLAGS_EN
//   Defined   -> overflow_o / underflow_o ports and their sticky registers.
//   Undefined -> the ports do not exist and no extra logic is built.
//
// Revision : 1.0 - initial release
// ============================================================================
module flex_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_i,
  input  logic                  rd_req_i,
  input  logic                  clear_i,
  output logic                  wclk_en_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o
`ifdef FLEX_FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic                  overflow_o,
  output logic                  underflow_o
`endif
);

  // Pointer increment and threshold constants, sized to the pointer width so
  // every arithmetic/compare operand has matching width.
  localparam logic [ADDR_WIDTH:0] c_ptr_inc      = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_afull_thresh = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] c_aempty_thresh = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  // --------------------------------------------------------------------------
  // Pointer state. One extra MSB per pointer acts as the wrap bit so that
  // full and empty are distinguishable without a separate counter.
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH:0] wptr_q;
  logic [ADDR_WIDTH:0] wptr_d;
  logic [ADDR_WIDTH:0] rptr_q;
  logic [ADDR_WIDTH:0] rptr_d;

  logic                w_full;
  logic                w_empty;
  logic [ADDR_WIDTH:0] w_count;
  logic                w_wr_accept;
  logic                w_rd_accept;

  // --------------------------------------------------------------------------
  // Flag decode, purely from the registered pointers. Flags therefore move
  // on the edge after an accepted operation, never combinationally from the
  // request inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    w_empty = (wptr_q == rptr_q);
    // Same slot, opposite lap: writer is exactly one full lap ahead.
    w_full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
              (wptr_q[ADDR_WIDTH]     != rptr_q[ADDR_WIDTH]);
    // Modular difference is correct across pointer rollover.
    w_count = wptr_q - rptr_q;
  end

  // --------------------------------------------------------------------------
  // Request acceptance. clear and rst both suppress acceptance so that a
  // flush or reset never leaves a half-written entry behind. A pop in the
  // same cycle does not make room for a push into a full FIFO, and a push
  // into an empty FIFO is not bypassed to the read side.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr_accept = wr_req_i & ~w_full  & ~clear_i & ~rst;
    w_rd_accept = rd_req_i & ~w_empty & ~clear_i & ~rst;
  end

  // --------------------------------------------------------------------------
  // Next-state pointers. clear forces both to zero; otherwise each pointer
  // advances independently, so a simultaneous push/pop leaves count alone.
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (w_wr_accept) begin
        wptr_d = wptr_q + c_ptr_inc;
      end
      if (w_rd_accept) begin
        rptr_d = rptr_q + c_ptr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    wclk_en_o      = w_wr_accept;
    waddr_o        = wptr_q[ADDR_WIDTH-1:0];
    raddr_o        = rptr_q[ADDR_WIDTH-1:0];
    full_o         = w_full;
    empty_o        = w_empty;
    count_o        = w_count;
    almost_full_o  = (w_count >= c_afull_thresh);
    almost_empty_o = (w_count <= c_aempty_thresh);
  end

`ifdef FLEX_FIFO_CTRL_ERR_FLAGS_EN
  // --------------------------------------------------------------------------
  // Sticky error flags. They record any rejected push/pop that was not
  // masked by a flush; rst and clear both win over a same-cycle set event.
  // --------------------------------------------------------------------------
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_req_i & w_full  & ~clear_i);
    underflow_d = underflow_q | (rd_req_i & w_empty & ~clear_i);
    if (clear_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  // Error tracking disabled: no sticky flag state is built.
`endif

endmodule
`default_nettype wire
